sev_seg_scan_controller: RTL

SEV_SEG_SCAN_CONTROLLER -- requirements
Module: sev_seg_scan_controller

---
 rtl/sev_seg_scan_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sev_seg_scan_controller.sv
// Four-digit multiplexed seven-segment scanner: each digit slot is a blanking gap then a show phase.
// Optional anode PWM dimming is enabled by defining SEV_SEG_SCAN_BRIGHTNESS_EN.
module sev_seg_scan_controller #(
  parameter int DIGIT_PERIOD = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] digit_0,
  input  logic [6:0] digit_1,
  input  logic [6:0] digit_2,
  input  logic [6:0] digit_3,
  input  logic [3:0] dots,
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick,
  output logic [1:0] dbg_state_o
);

  localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_PERIOD - BLANK_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       pat_q, pat_d;
  logic             dot_q, dot_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             dp_n_q, dp_n_d;
  logic             tick_q, tick_d;
  logic [6:0]       sel_pat;

  always_comb begin
    case (idx_q)
      2'd0:    sel_pat = digit_0;
      2'd1:    sel_pat = digit_1;
      2'd2:    sel_pat = digit_2;
      default: sel_pat = digit_3;
    endcase
  end

  // Pattern and dot are captured once per slot so mid-slot input changes never tear the display.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dot_d   = dot_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          pat_d   = sel_pat;
          dot_d   = dots[idx_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          tick_d  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so they line up with state_q.
`ifdef SEV_SEG_SCAN_BRIGHTNESS_EN
  logic [31:0] cnt_ext;
  logic        pwm_on;
  always_comb begin
    cnt_ext = 32'(cnt_d);
    pwm_on  = ((cnt_ext & 32'hF) <= {28'd0, brightness});
  end
`else
  logic pwm_on;
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (state_d == SHOW) begin
      if (pwm_on) an_n_d[idx_d] = 1'b0;
      seg_n_d = ~pat_d;
      dp_n_d  = ~dot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      pat_q   <= 7'h00;
      dot_q   <= 1'b0;
      an_n_q  <= 4'hF;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dot_q   <= dot_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      tick_q  <= tick_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign frame_tick  = tick_q;
  assign dbg_state_o = state_q;

endmodule
